// File: rtl/io_input_debounce.sv
// Three-channel input conditioner: 2-FF synchroniser plus word-level debounce
// feeding the CPU input-port block, with per-channel change pulse and sticky flag.
module io_input_debounce #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic             io_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_port0,
   input  logic [WIDTH-1:0] raw_port1,
   input  logic [WIDTH-1:0] raw_port2,
   input  logic [2:0]       chg_clr,
   output logic [WIDTH-1:0] out_port0,
   output logic [WIDTH-1:0] out_port1,
   output logic [WIDTH-1:0] out_port2,
   output logic [2:0]       chg_pulse,
   output logic [2:0]       chg_flag
);

   localparam int unsigned NCH   = 3;
   localparam int unsigned CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [WIDTH-1:0] raw_a [NCH];
   logic [WIDTH-1:0] out_a [NCH];

   assign raw_a[0]  = raw_port0;
   assign raw_a[1]  = raw_port1;
   assign raw_a[2]  = raw_port2;
   assign out_port0 = out_a[0];
   assign out_port1 = out_a[1];
   assign out_port2 = out_a[2];

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [WIDTH-1:0] sync1;
      logic [WIDTH-1:0] sync2;
      logic [WIDTH-1:0] cand;
      logic [WIDTH-1:0] out_q;
      logic [CNT_W-1:0] cnt;
      logic             pulse_q;
      logic             flag_q;
      logic             upd;

      // Candidate held long enough and differs from what is presented downstream.
      assign upd = (sync2 == cand) && (cnt == CNT_MAX) && (cand != out_q);

      always_ff @(posedge io_clk) begin
         if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            cand    <= '0;
            cnt     <= '0;
            out_q   <= '0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
         end else begin
            sync1 <= raw_a[g];
            sync2 <= sync1;
            if (sync2 != cand) begin
               cand <= sync2;
               cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_W'(1);
            end
            if (upd) begin
               out_q <= cand;
            end
            pulse_q <= upd;
            // A set on the same edge as a clear wins.
            flag_q  <= (flag_q & ~chg_clr[g]) | upd;
         end
      end

      assign out_a[g]     = out_q;
      assign chg_pulse[g] = pulse_q;
      assign chg_flag[g]  = flag_q;
   end

endmodule
